// File: rtl/position_stream_tx.sv
// position_stream_tx
//   Transmit end of the serial board-load bus feeding the move generator.
//   Stores a 64-square board image plus side-to-move, castle rights and
//   en-passant state, applies one UCI move per handshake and streams the
//   resulting position as 64 nibbles (square 63 first, square 0 last).
//   The emitted position can optionally be committed back into storage.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_pos_valid/data/eop    board load stream (square 63 first)
//   in_wtp/castle/ep/ep_valid  position metadata, sampled on the eop beat
//   board_valid              stored board is complete
//   in_move_valid/ready/data move handshake, 20-bit UCI move
//   in_move_commit           write the emitted position back to storage
//   out_pos_valid/data/eop   emitted position stream
//   out_wtp/castle/ep/ep_valid metadata, held during the 64 beats, else 0
module position_stream_tx #(
   parameter int SQUARES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_pos_valid,
   input  logic [3:0]  in_pos_data,
   input  logic        in_pos_eop,
   input  logic        in_wtp,
   input  logic [3:0]  in_castle,
   input  logic [2:0]  in_ep,
   input  logic        in_ep_valid,
   output logic        board_valid,
   input  logic        in_move_valid,
   output logic        in_move_ready,
   input  logic [19:0] in_move_data,
   input  logic        in_move_commit,
   output logic        out_pos_valid,
   output logic [3:0]  out_pos_data,
   output logic        out_pos_eop,
   output logic        out_wtp,
   output logic [3:0]  out_castle,
   output logic [2:0]  out_ep,
   output logic        out_ep_valid
);

   localparam logic [5:0] LAST_SQ = 6'(SQUARES - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   // Promotion field to piece type: queen, bishop, rook, knight.
   function automatic logic [2:0] prom_type(input logic [1:0] sel);
      case (sel)
         2'd0:    prom_type = 3'd2;
         2'd1:    prom_type = 3'd4;
         2'd2:    prom_type = 3'd3;
         default: prom_type = 3'd5;
      endcase
   endfunction

   // Castle-right bit owned by a corner square: h0->WK, a0->WQ, h7->BK, a7->BQ.
   function automatic logic [3:0] corner_mask(input logic [5:0] sq);
      case (sq)
         6'd7:    corner_mask = 4'b0001;
         6'd0:    corner_mask = 4'b0010;
         6'd63:   corner_mask = 4'b0100;
         6'd56:   corner_mask = 4'b1000;
         default: corner_mask = 4'b0000;
      endcase
   endfunction

   logic [0:0] state_r;
   logic [5:0] load_cnt_r;
   logic       load_ovf_r;
   logic       board_valid_r;
   logic       stm_r;
   logic [3:0] castle_r;
   logic [2:0] ep_r;
   logic       ep_valid_r;
   logic [3:0] mem_r [0:63];
   logic [6:0] emit_cnt_r;
   logic       commit_r;

   // Move decoded at accept time, held for the whole emission.
   logic       mv_active_r;
   logic [5:0] mv_from_r;
   logic [5:0] mv_to_r;
   logic [3:0] mv_to_nib_r;
   logic       mv_castle_r;
   logic [5:0] mv_rook_from_r;
   logic [5:0] mv_rook_to_r;
   logic [3:0] mv_rook_nib_r;
   logic       mv_ep_r;
   logic [5:0] mv_ep_sq_r;
   logic       nx_wtp_r;
   logic [3:0] nx_castle_r;
   logic [2:0] nx_ep_r;
   logic       nx_ep_valid_r;

   logic       out_pos_valid_r;
   logic [3:0] out_pos_data_r;
   logic       out_pos_eop_r;
   logic       out_wtp_r;
   logic [3:0] out_castle_r;
   logic [2:0] out_ep_r;
   logic       out_ep_valid_r;

   // Move field decode.
   logic [1:0] prom_s;
   logic [2:0] moved_s;
   logic [2:0] from_rank_s;
   logic [2:0] from_file_s;
   logic [2:0] to_rank_s;
   logic [2:0] to_file_s;
   logic [5:0] from_sq_s;
   logic [5:0] to_sq_s;
   logic       colour_s;
   logic       is_pawn_s;
   logic       promo_s;
   logic       castle_move_s;
   logic       ep_capture_s;
   logic       double_push_s;
   logic [3:0] king_mask_s;
   logic       move_fire_s;
   logic       taken_unused_s;

   assign prom_s         = in_move_data[19:18];
   assign moved_s        = in_move_data[17:15];
   assign from_rank_s    = in_move_data[14:12];
   assign from_file_s    = in_move_data[11:9];
   assign taken_unused_s = ^in_move_data[8:6];
   assign to_rank_s      = in_move_data[5:3];
   assign to_file_s      = in_move_data[2:0];
   assign from_sq_s      = {from_rank_s, from_file_s};
   assign to_sq_s        = {to_rank_s, to_file_s};
   assign colour_s       = ~stm_r;
   assign is_pawn_s      = (moved_s == 3'd6);
   // Last rank for the side to move: rank 7 for white, rank 0 for black.
   assign promo_s        = is_pawn_s & (to_rank_s == (stm_r ? 3'd7 : 3'd0));
   assign castle_move_s  = (moved_s == 3'd1) & (from_file_s == 3'd4) &
                           ((to_file_s == 3'd6) | (to_file_s == 3'd2));
   // Diagonal pawn move onto an empty square can only be en passant.
   assign ep_capture_s   = is_pawn_s & (from_file_s != to_file_s) &
                           (mem_r[to_sq_s] == 4'd0);
   assign double_push_s  = is_pawn_s &
                           (({1'b0, to_rank_s} == ({1'b0, from_rank_s} + 4'd2)) |
                            ({1'b0, from_rank_s} == ({1'b0, to_rank_s} + 4'd2)));
   assign king_mask_s    = (moved_s == 3'd1) ? (stm_r ? 4'b0011 : 4'b1100) : 4'b0000;

   assign in_move_ready  = (state_r == ST_IDLE) & board_valid_r & ~in_pos_valid;
   assign move_fire_s    = in_move_valid & in_move_ready;

   // Emission cursor: square 63 on the first compute cycle down to square 0.
   logic       emit_active_s;
   logic [5:0] emit_sq_s;
   logic [3:0] emit_nib_s;

   assign emit_active_s = (state_r == ST_EMIT) & ~emit_cnt_r[6];
   assign emit_sq_s     = LAST_SQ - emit_cnt_r[5:0];

   // Nibble for the square under the cursor, highest priority first.
   always_comb begin
      emit_nib_s = mem_r[emit_sq_s];
      if (!mv_active_r) begin
         emit_nib_s = mem_r[emit_sq_s];
      end else if (emit_sq_s == mv_from_r) begin
         emit_nib_s = 4'd0;
      end else if (emit_sq_s == mv_to_r) begin
         emit_nib_s = mv_to_nib_r;
      end else if (mv_castle_r && (emit_sq_s == mv_rook_from_r)) begin
         emit_nib_s = 4'd0;
      end else if (mv_castle_r && (emit_sq_s == mv_rook_to_r)) begin
         emit_nib_s = mv_rook_nib_r;
      end else if (mv_ep_r && (emit_sq_s == mv_ep_sq_r)) begin
         emit_nib_s = 4'd0;
      end else begin
         emit_nib_s = mem_r[emit_sq_s];
      end
   end

   // Control: load counter, stored metadata, state and emission counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         load_cnt_r    <= LAST_SQ;
         load_ovf_r    <= 1'b0;
         board_valid_r <= 1'b0;
         stm_r         <= 1'b0;
         castle_r      <= 4'd0;
         ep_r          <= 3'd0;
         ep_valid_r    <= 1'b0;
         emit_cnt_r    <= 7'd0;
         commit_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_pos_valid) begin
                  if (in_pos_eop) begin
                     if (load_cnt_r == 6'd0) begin
                        stm_r         <= in_wtp;
                        castle_r      <= in_castle;
                        ep_r          <= in_ep;
                        ep_valid_r    <= in_ep_valid;
                        board_valid_r <= 1'b1;
                     end else begin
                        board_valid_r <= 1'b0;
                     end
                     load_cnt_r <= LAST_SQ;
                     load_ovf_r <= 1'b0;
                  end else begin
                     board_valid_r <= 1'b0;
                     if (load_cnt_r != 6'd0) begin
                        load_cnt_r <= load_cnt_r - 6'd1;
                     end else begin
                        load_ovf_r <= 1'b1;
                     end
                  end
               end else if (move_fire_s) begin
                  state_r    <= ST_EMIT;
                  emit_cnt_r <= 7'd0;
                  commit_r   <= in_move_commit;
               end
            end
            ST_EMIT: begin
               if (emit_active_s) begin
                  emit_cnt_r <= emit_cnt_r + 7'd1;
                  // Metadata is replaced together with the final square so
                  // the colour used for the whole stream stays consistent.
                  if (commit_r && (emit_sq_s == 6'd0)) begin
                     stm_r      <= nx_wtp_r;
                     castle_r   <= nx_castle_r;
                     ep_r       <= nx_ep_r;
                     ep_valid_r <= nx_ep_valid_r;
                  end
               end else begin
                  // Eop beat is on the outputs now; back to idle next cycle.
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Capture the decoded move and the resulting metadata on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         mv_active_r    <= 1'b0;
         mv_from_r      <= 6'd0;
         mv_to_r        <= 6'd0;
         mv_to_nib_r    <= 4'd0;
         mv_castle_r    <= 1'b0;
         mv_rook_from_r <= 6'd0;
         mv_rook_to_r   <= 6'd0;
         mv_rook_nib_r  <= 4'd0;
         mv_ep_r        <= 1'b0;
         mv_ep_sq_r     <= 6'd0;
         nx_wtp_r       <= 1'b0;
         nx_castle_r    <= 4'd0;
         nx_ep_r        <= 3'd0;
         nx_ep_valid_r  <= 1'b0;
      end else if (move_fire_s) begin
         mv_active_r    <= (moved_s != 3'd0);
         mv_from_r      <= from_sq_s;
         mv_to_r        <= to_sq_s;
         mv_to_nib_r    <= {colour_s, (promo_s ? prom_type(prom_s) : moved_s)};
         mv_castle_r    <= castle_move_s;
         mv_rook_from_r <= {from_rank_s, ((to_file_s == 3'd6) ? 3'd7 : 3'd0)};
         mv_rook_to_r   <= {from_rank_s, ((to_file_s == 3'd6) ? 3'd5 : 3'd3)};
         mv_rook_nib_r  <= {colour_s, 3'd3};
         mv_ep_r        <= ep_capture_s;
         mv_ep_sq_r     <= {from_rank_s, to_file_s};
         if (moved_s == 3'd0) begin
            // Null move re-emits the stored metadata untouched.
            nx_wtp_r      <= stm_r;
            nx_castle_r   <= castle_r;
            nx_ep_r       <= ep_r;
            nx_ep_valid_r <= ep_valid_r;
         end else begin
            nx_wtp_r      <= ~stm_r;
            nx_castle_r   <= castle_r & ~(king_mask_s | corner_mask(from_sq_s) |
                                          corner_mask(to_sq_s));
            nx_ep_r       <= to_file_s;
            nx_ep_valid_r <= double_push_s;
         end
      end
   end

   // Board storage: load beats in idle, committed nibbles during emission.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if ((state_r == ST_IDLE) && in_pos_valid && !load_ovf_r) begin
            mem_r[load_cnt_r] <= in_pos_data;
         end else if (emit_active_s && commit_r) begin
            mem_r[emit_sq_s] <= emit_nib_s;
         end
      end
   end

   // Registered output stream and metadata, zero outside emission.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_pos_valid_r <= 1'b0;
         out_pos_data_r  <= 4'd0;
         out_pos_eop_r   <= 1'b0;
         out_wtp_r       <= 1'b0;
         out_castle_r    <= 4'd0;
         out_ep_r        <= 3'd0;
         out_ep_valid_r  <= 1'b0;
      end else if (emit_active_s) begin
         out_pos_valid_r <= 1'b1;
         out_pos_data_r  <= emit_nib_s;
         out_pos_eop_r   <= (emit_sq_s == 6'd0);
         out_wtp_r       <= nx_wtp_r;
         out_castle_r    <= nx_castle_r;
         out_ep_r        <= nx_ep_r;
         out_ep_valid_r  <= nx_ep_valid_r;
      end else begin
         out_pos_valid_r <= 1'b0;
         out_pos_data_r  <= 4'd0;
         out_pos_eop_r   <= 1'b0;
         out_wtp_r       <= 1'b0;
         out_castle_r    <= 4'd0;
         out_ep_r        <= 3'd0;
         out_ep_valid_r  <= 1'b0;
      end
   end

   assign board_valid   = board_valid_r;
   assign out_pos_valid = out_pos_valid_r;
   assign out_pos_data  = out_pos_data_r;
   assign out_pos_eop   = out_pos_eop_r;
   assign out_wtp       = out_wtp_r;
   assign out_castle    = out_castle_r;
   assign out_ep        = out_ep_r;
   assign out_ep_valid  = out_ep_valid_r;

endmodule

// File: doc/position_stream_tx.md
Name: position_stream_tx

Overview:
- Transmit end of the serial board-load bus consumed by the pseudo-legal move generator.
- Holds a 64-square board image and accepts one 20-bit UCI move per handshake.
- Applies the move: capture, promotion, castling rook hop, en-passant removal, castle-rights and ep-file update.
- Streams the resulting position as 64 nibbles plus side-to-move, castle and ep metadata, and optionally commits it as the new stored board.

Parameters:
- SQUARES, 64, squares per position; fixed at 64, present for bench sizing only.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_pos_valid  in  1  load beat valid
- in_pos_data  in  4  load nibble {black, type[2:0]}; type: 0 none, 1 king, 2 queen, 3 rook, 4 bishop, 5 knight, 6 pawn
- in_pos_eop  in  1  last load beat
- in_wtp  in  1  white to play; sampled on the eop beat
- in_castle  in  4  castle rights [0]WK [1]WQ [2]BK [3]BQ; sampled on the eop beat
- in_ep  in  3  ep file; sampled on the eop beat
- in_ep_valid  in  1  ep file valid; sampled on the eop beat
- board_valid  out  1  stored board is complete
- in_move_valid  in  1  move offered
- in_move_ready  out  1  move accepted when high with in_move_valid
- in_move_data  in  20  {prom[1:0], moved[2:0], from_r, from_f, taken[2:0], to_r, to_f}
- in_move_commit  in  1  write the emitted position back to storage
- out_pos_valid  out  1  emit beat valid
- out_pos_data  out  4  emit nibble
- out_pos_eop  out  1  64th beat
- out_wtp  out  1  valid during emission
- out_castle  out  4  valid during emission
- out_ep  out  3  valid during emission
- out_ep_valid  out  1  valid during emission

Behaviour:
- Reset: all outputs 0, board_valid=0, state IDLE, load counter=63, memory contents don't-care. Reset mid-emit aborts with no further beats and no partial commit guarantee (board_valid=0).
- Square index is r*8+f. Load and emit order is index 63 first, index 0 last, so the first nibble shifted into a receiver chain lands on square 63.
- States: IDLE, EMIT.
- Load (IDLE only):
  - Each in_pos_valid beat writes memory[cnt]; cnt decrements.
  - eop with cnt==0: latches wtp/castle/ep, sets board_valid=1, cnt=63.
  - eop with cnt!=0: short load; board_valid=0, cnt=63.
  - Beats after cnt reaches 0 without eop are dropped.
  - A load beat without eop clears board_valid.
  - in_pos_valid in EMIT is ignored.
- in_move_ready = (state==IDLE) & board_valid & ~in_pos_valid.
- Accept at cycle T: move and commit registered at T+1; first out beat at T+2. 64 consecutive beats follow, eop on the 64th; state returns to IDLE the cycle after eop.
- Metadata outputs hold stable across all 64 beats and are 0 otherwise.
- Emitted nibble for square s, with stm = stored wtp and colour bit C = ~stm:
  - s==from -> 0.
  - s==to -> {C, moved}; if moved==6 and to_r==7 (white) or 0 (black), type = prom map 0 queen, 1 bishop, 2 rook, 3 knight.
  - Castle (moved==1, from_f==4, |to_f-from_f|==2): rook square (to_f==6 ? f7 : f0) -> 0; (to_f==6 ? f5 : f3) -> {C,3}; rank = from_r.
  - En passant (moved==6, from_f!=to_f, stored square at to is empty): square (from_r, to_f) -> 0.
  - All other squares: stored nibble.
- Metadata:
  - out_wtp = ~stm.
  - out_ep_valid = moved==6 & |to_r-from_r|==2; out_ep = to_f.
  - out_castle = stored rights with clears: king moved clears both rights of stm; from or to at a0/h0/a7/h7 clears the matching bit.
- moved==0 (null move): position, wtp, castle and ep re-emitted unchanged.
- The taken field is informational only; the stored board decides captures.
- Commit=1: each emitted nibble is written to its square in the same cycle, and stored metadata is replaced on eop. Commit=0: storage is unchanged.

Test Plan:
- Start position loaded (sq0..7 = 3,5,4,2,1,4,5,3; sq8..15 = 6; sq48..55 = E; sq56..63 = B,D,C,A,9,C,D,B); move e2e4 {0,6,1,4,0,3,4} -> beat for sq12=0, sq28=0x6, out_wtp=0, out_ep_valid=1, out_ep=4, eop only on beat 64, first beat at T+2.
- White king on sq4, rook on sq7, castle=F; move {0,1,0,4,0,0,6} -> sq4=0, sq5=0x3, sq6=0x1, sq7=0, out_castle=0xC.
- White pawn on sq48, black knight on sq57; move {2,6,6,0,5,7,1} -> sq57=0x3, sq48=0, out_castle unchanged.
- White pawn on sq36, black pawn on sq37, ep_valid=1, ep=5; move {0,6,4,4,0,5,5} -> sq45=0x6, sq37=0, sq36=0.
- Commit=1 e2e4, then null move -> second stream equals the first with wtp=0, in_move_ready low for 65 cycles after each accept, in_pos_valid pulses during EMIT have no effect.
- Load with eop on beat 10 -> board_valid=0, in_move_ready=0; a following full 64-beat load -> board_valid=1.
